// File: rtl/usb_burst_packer_pkg.sv
// Shared definitions for the USB IN burst packer: packet-size limits and FSM state encoding.
package usb_burst_packer_pkg;

   localparam int unsigned MPS_FS = 64;
   localparam int unsigned MPS_HS = 512;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_XFER,
      ST_ZLP,
      ST_DRAIN
   } state_e;

endpackage

// File: rtl/usb_burst_packer.sv
// Splits one source AXI4-Stream transfer into USB IN packets of at most max-packet-size bytes,
// clipped to the host-requested length, with ZLP signalling and draining of unsent source bytes.
module usb_burst_packer
   import usb_burst_packer_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned MAXLEN      = MPS_HS,
   parameter int unsigned LENGTH_BITS = 16,
   localparam int unsigned CBITS      = $clog2(MAXLEN + 1)
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   start_i,
   input  logic [LENGTH_BITS-1:0] length_i,
   input  logic [CBITS-1:0]       maxpkt_i,
   input  logic                   abort_i,
   input  logic                   pkt_req_i,
   output logic                   busy_o,
   output logic                   zlp_o,
   output logic                   done_o,
   input  logic                   s_tvalid,
   output logic                   s_tready,
   input  logic                   s_tlast,
   input  logic [WIDTH-1:0]       s_tdata,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic                   m_tlast,
   output logic [WIDTH-1:0]       m_tdata
);

   localparam logic [CBITS-1:0] MAXLEN_C = CBITS'(MAXLEN);

   state_e                 state_q, state_d;
   logic [LENGTH_BITS-1:0] rem_q, rem_d;
   logic [CBITS-1:0]       mps_q, mps_d;
   logic [CBITS-1:0]       cnt_q, cnt_d;
   logic                   src_end_q, src_end_d;
   logic                   s_beat;
   logic                   pkt_full;
   logic                   pkt_last;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         rem_q     <= '0;
         mps_q     <= '0;
         cnt_q     <= '0;
         src_end_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         mps_q     <= mps_d;
         cnt_q     <= cnt_d;
         src_end_q <= src_end_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      mps_d     = mps_q;
      cnt_d     = cnt_q;
      src_end_d = src_end_q;
      busy_o    = (state_q != ST_IDLE);
      zlp_o     = 1'b0;
      done_o    = 1'b0;
      s_tready  = 1'b0;
      m_tvalid  = 1'b0;
      m_tlast   = 1'b0;
      m_tdata   = s_tdata;
      s_beat    = 1'b0;
      pkt_full  = (cnt_q == mps_q - CBITS'(1));
      pkt_last  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               rem_d     = length_i;
               mps_d     = (maxpkt_i == '0 || maxpkt_i > MAXLEN_C) ? MAXLEN_C : maxpkt_i;
               cnt_d     = '0;
               src_end_d = 1'b0;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (pkt_req_i) begin
               if (rem_q == '0 || src_end_q) begin
                  state_d = ST_ZLP;
               end else begin
                  cnt_d   = '0;
                  state_d = ST_XFER;
               end
            end
         end
         ST_XFER: begin
            m_tvalid = s_tvalid;
            s_tready = m_tready;
            pkt_last = s_tlast | pkt_full | (rem_q == LENGTH_BITS'(1));
            m_tlast  = pkt_last;
            s_beat   = s_tvalid & m_tready;
            if (s_beat) begin
               cnt_d = cnt_q + CBITS'(1);
               if (rem_q != '0) begin
                  rem_d = rem_q - LENGTH_BITS'(1);
               end
               if (pkt_last) begin
                  // A short packet or an exhausted request ends the transfer; a full packet
                  // with bytes still owed waits for the next IN token.
                  if (!pkt_full || rem_q == LENGTH_BITS'(1)) begin
                     done_o  = 1'b1;
                     state_d = s_tlast ? ST_IDLE : ST_DRAIN;
                  end else begin
                     src_end_d = s_tlast;
                     state_d   = ST_WAIT;
                  end
               end
            end
         end
         ST_ZLP: begin
            zlp_o   = 1'b1;
            done_o  = 1'b1;
            state_d = src_end_q ? ST_IDLE : ST_DRAIN;
         end
         ST_DRAIN: begin
            s_tready = 1'b1;
            if (s_tvalid && s_tlast) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort overrides every non-idle state; a final beat accepted this cycle ends the source.
      if (abort_i && state_q != ST_IDLE) begin
         m_tvalid  = 1'b0;
         m_tlast   = 1'b0;
         zlp_o     = 1'b0;
         done_o    = 1'b0;
         src_end_d = src_end_q;
         state_d   = (src_end_q || (s_tvalid && s_tready && s_tlast)) ? ST_IDLE : ST_DRAIN;
      end
   end

endmodule
